// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: opcodes, address-exception
// codes, handshake FSM encodings and the EX/MEM stage register layout.
package mem_stage_pkg;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } size_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] ao;
    logic [31:0] rt;
    logic [31:0] wd;
    logic [4:0]  tar;
    logic        grf_we;
    logic [3:0]  tnew;
    logic [4:0]  exc;
    logic        bd;
  } stage_t;

endpackage

// File: rtl/mem_stage_ext.sv
// Combinational lane logic: store byte enables / replicated store data and
// load byte/half selection with sign or zero extension.
module mem_ext
  import mem_stage_pkg::*;
(
  input  size_e       size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        sign_i,
  input  logic [31:0] rt_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ldata_o
);

  logic [7:0]  lbyte;
  logic [15:0] lhalf;

  always_comb begin
    case (addr_lo_i)
      2'd0:    lbyte = rdata_i[7:0];
      2'd1:    lbyte = rdata_i[15:8];
      2'd2:    lbyte = rdata_i[23:16];
      default: lbyte = rdata_i[31:24];
    endcase
    lhalf = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = rt_i;
    ldata_o = rdata_i;
    case (size_i)
      SZ_BYTE: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{rt_i[7:0]}};
        ldata_o = sign_i ? {{24{lbyte[7]}}, lbyte} : {24'd0, lbyte};
      end
      SZ_HALF: begin
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{rt_i[15:0]}};
        ldata_o = sign_i ? {{16{lhalf[15]}}, lhalf} : {16'd0, lhalf};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: EX/MEM register, load/store decode, address
// exception detection and a request/ready bus handshake that stalls the pipe.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter logic [31:0] DM_HI   = 32'h0000_2FFF,
  parameter logic [31:0] T0_BASE = 32'h0000_7F00,
  parameter logic [31:0] T1_BASE = 32'h0000_7F10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] e_instr,
  input  logic [31:0] e_pc,
  input  logic [31:0] e_ao,
  input  logic [31:0] e_rt,
  input  logic [4:0]  e_tar_reg,
  input  logic [31:0] e_wd,
  input  logic        e_grf_we,
  input  logic [3:0]  e_tnew,
  input  logic [4:0]  e_exc,
  input  logic        e_bd,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready,
  output logic        mem_busy,
  output logic [31:0] m_instr,
  output logic [31:0] m_pc,
  output logic [4:0]  m_tar_reg,
  output logic [31:0] m_wd,
  output logic        m_grf_we,
  output logic [3:0]  m_tnew,
  output logic [4:0]  m_exc,
  output logic        m_bd,
  output logic [31:0] m_badvaddr,
  output logic [4:0]  fwd_reg,
  output logic [31:0] fwd_val,
  output logic        fwd_valid
);

  stage_t      stage_q, stage_d;
  logic [0:0]  state_q, state_d;
  logic        flush_pending_q, flush_pending_d;

  logic        is_load, is_store, is_mem, ld_sign;
  size_e       size;
  logic        in_dm, in_tmr, misalign, cnt_store, bad_addr;
  logic        new_exc, access, kill;
  logic [3:0]  be;
  logic [31:0] wdata, ldata;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    size     = SZ_WORD;
    ld_sign  = 1'b0;
    case (stage_q.instr[31:26])
      OP_LB:   begin is_load = 1'b1;  size = SZ_BYTE; ld_sign = 1'b1; end
      OP_LH:   begin is_load = 1'b1;  size = SZ_HALF; ld_sign = 1'b1; end
      OP_LW:   begin is_load = 1'b1;  size = SZ_WORD; end
      OP_LBU:  begin is_load = 1'b1;  size = SZ_BYTE; end
      OP_LHU:  begin is_load = 1'b1;  size = SZ_HALF; end
      OP_SB:   begin is_store = 1'b1; size = SZ_BYTE; end
      OP_SH:   begin is_store = 1'b1; size = SZ_HALF; end
      OP_SW:   begin is_store = 1'b1; size = SZ_WORD; end
      default: ;
    endcase
  end

  assign is_mem    = is_load | is_store;
  assign in_dm     = stage_q.ao <= DM_HI;
  assign in_tmr    = (stage_q.ao >= T0_BASE && stage_q.ao <= T0_BASE + 32'd11) ||
                     (stage_q.ao >= T1_BASE && stage_q.ao <= T1_BASE + 32'd11);
  assign misalign  = ((size == SZ_WORD) && (stage_q.ao[1:0] != 2'b00)) ||
                     ((size == SZ_HALF) && stage_q.ao[0]);
  // Timer count registers are read-only.
  assign cnt_store = is_store && (stage_q.ao == T0_BASE + 32'd8 || stage_q.ao == T1_BASE + 32'd8);
  assign bad_addr  = misalign || !(in_dm || in_tmr) || (in_tmr && size != SZ_WORD) || cnt_store;

  // An exception already carried from upstream masks any new one.
  assign new_exc   = is_mem && (stage_q.exc == 5'd0) && bad_addr;
  assign access    = is_mem && (stage_q.exc == 5'd0) && !bad_addr;
  assign kill      = new_exc || flush_pending_q;

  assign bus_req   = (state_q == ST_WAIT) || access;
  assign mem_busy  = bus_req && !bus_ready;
  assign bus_we    = bus_req && is_store;
  assign bus_addr  = bus_req ? {stage_q.ao[31:2], 2'b00} : 32'd0;
  assign bus_be    = bus_req ? be : 4'd0;
  assign bus_wdata = bus_we ? wdata : 32'd0;

  mem_ext u_ext (
    .size_i   (size),
    .addr_lo_i(stage_q.ao[1:0]),
    .sign_i   (ld_sign),
    .rt_i     (stage_q.rt),
    .rdata_i  (bus_rdata),
    .be_o     (be),
    .wdata_o  (wdata),
    .ldata_o  (ldata)
  );

  assign m_instr    = kill ? 32'd0 : stage_q.instr;
  assign m_grf_we   = kill ? 1'b0 : stage_q.grf_we;
  assign m_pc       = stage_q.pc;
  assign m_tar_reg  = stage_q.tar;
  assign m_bd       = stage_q.bd;
  assign m_wd       = (is_load && bus_req && bus_ready) ? ldata : stage_q.wd;
  assign m_tnew     = (stage_q.tnew == 4'd0) ? 4'd0 : stage_q.tnew - 4'd1;
  assign m_exc      = (stage_q.exc != 5'd0) ? stage_q.exc :
                      new_exc ? (is_load ? EXC_ADEL : EXC_ADES) : 5'd0;
  assign m_badvaddr = new_exc ? stage_q.ao : 32'd0;

  assign fwd_reg    = stage_q.tar;
  assign fwd_val    = stage_q.wd;
  assign fwd_valid  = stage_q.grf_we && (stage_q.tar != 5'd0) && !is_load;

  always_comb begin
    stage_d = stage_q;
    if (!mem_busy) begin
      if (flush || flush_pending_q) begin
        stage_d = '0;
      end else begin
        stage_d = '{instr: e_instr, pc: e_pc, ao: e_ao, rt: e_rt, wd: e_wd,
                    tar: e_tar_reg, grf_we: e_grf_we, tnew: e_tnew,
                    exc: e_exc, bd: e_bd};
      end
    end
  end

  assign flush_pending_d = mem_busy ? (flush_pending_q || flush) : 1'b0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus_req && !bus_ready) state_d = ST_WAIT;
      default: if (bus_ready) state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q         <= '0;
      state_q         <= ST_IDLE;
      flush_pending_q <= 1'b0;
    end else begin
      stage_q         <= stage_d;
      state_q         <= state_d;
      flush_pending_q <= flush_pending_d;
    end
  end

endmodule
